// File: rtl/linreg_predict.sv
`timescale 1ns/1ps
// linreg_predict
// Fixed-point linear-regression predictor. A weight vector W0..W15 is captured
// on w_load; each accepted row (y, x1..x15) produces
//   y_cap = sat(W0 + sum_{j=1..feat} Wj*xj)   and   y_err = sat(y - y_cap)
// with one multiply-accumulate per cycle.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   w_load, weights     one-cycle strobe + packed W0..W15 (W0 in the top field)
//   feat                active feature count, sampled with the row
//   x_valid/x_ready     row handshake, x_data packs y in field 0, xj in field j
//   y_valid/y_ready     prediction handshake, y_cap / y_err held while stalled
//   w_loaded            a weight set has been captured since reset
//   pred_count          predictions delivered (wrapping)
module linreg_predict #(
  parameter int LENGTH       = 16,
  parameter int MAX_FEATURES = 15,
  parameter int FRAC         = 8,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  w_load,
  input  logic [DATA_WIDTH-1:0] weights,
  input  logic [3:0]            feat,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [LENGTH-1:0]     y_cap,
  output logic [LENGTH-1:0]     y_err,
  output logic                  w_loaded,
  output logic [ADDR_WIDTH-1:0] pred_count
);

  // state | meaning
  // NOWT  | no weights captured yet, rows refused
  // READY | weights valid, waiting for a row (w_load still honoured)
  // MAC   | accumulating W[idx]*x[idx], one product per cycle
  // OUT   | prediction presented, waiting for y_ready

  // 15 full-width products plus W0 fit with 4 guard bits.
  localparam int ACC_W = 2*LENGTH + 4;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (LENGTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {NOWT, READY, MAC, OUT} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   w_reg;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic [3:0]              feat_reg;
  logic [3:0]              idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_shr;

  logic signed [LENGTH-1:0]   w_arr [0:MAX_FEATURES];
  logic signed [LENGTH-1:0]   x_arr [0:MAX_FEATURES];
  logic signed [LENGTH-1:0]   w0_sel;
  logic signed [LENGTH-1:0]   y_sel;
  logic signed [2*LENGTH-1:0] w_ext;
  logic signed [2*LENGTH-1:0] x_ext;
  logic signed [2*LENGTH-1:0] prod;
  logic signed [LENGTH:0]     diff;
  logic [LENGTH-1:0]          y_cap_nxt;
  logic [LENGTH-1:0]          y_err_nxt;
  logic                       x_hs;

  for (genvar j = 0; j <= MAX_FEATURES; j++) begin : g_unpack
    assign w_arr[j] = w_reg[DATA_WIDTH-1-LENGTH*j -: LENGTH];
    assign x_arr[j] = x_reg[DATA_WIDTH-1-LENGTH*j -: LENGTH];
  end

  assign x_hs = x_valid && x_ready;

  // A w_load coinciding with the row handshake supplies that row's W0.
  assign w0_sel = w_load ? weights[DATA_WIDTH-1 -: LENGTH] : w_arr[0];
  // feat=0 rows go straight to OUT, so y comes from the live input then.
  assign y_sel  = (state == READY) ? x_data[DATA_WIDTH-1 -: LENGTH] : x_arr[0];

  assign w_ext = {{LENGTH{w_arr[idx][LENGTH-1]}}, w_arr[idx]};
  assign x_ext = {{LENGTH{x_arr[idx][LENGTH-1]}}, x_arr[idx]};
  assign prod  = w_ext * x_ext;

  always_comb begin
    acc_nxt = acc;
    if (state == READY && x_hs)
      acc_nxt = {{(ACC_W-LENGTH-FRAC){w0_sel[LENGTH-1]}}, w0_sel, {FRAC{1'b0}}};
    else if (state == MAC)
      acc_nxt = acc + {{(ACC_W-2*LENGTH){prod[2*LENGTH-1]}}, prod};
  end

  assign acc_shr = acc_nxt >>> FRAC;

  always_comb begin
    if (acc_shr > Y_MAX)
      y_cap_nxt = Y_MAX[LENGTH-1:0];
    else if (acc_shr < Y_MIN)
      y_cap_nxt = Y_MIN[LENGTH-1:0];
    else
      y_cap_nxt = acc_shr[LENGTH-1:0];
  end

  // One extra bit holds the exact difference; top two bits disagree on overflow.
  assign diff = {y_sel[LENGTH-1], y_sel} - {y_cap_nxt[LENGTH-1], y_cap_nxt};

  always_comb begin
    if (diff[LENGTH] != diff[LENGTH-1])
      y_err_nxt = diff[LENGTH] ? {1'b1, {(LENGTH-1){1'b0}}} : {1'b0, {(LENGTH-1){1'b1}}};
    else
      y_err_nxt = diff[LENGTH-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= NOWT;
      w_reg      <= '0;
      x_reg      <= '0;
      feat_reg   <= '0;
      idx        <= '0;
      acc        <= '0;
      x_ready    <= 1'b0;
      y_valid    <= 1'b0;
      y_cap      <= '0;
      y_err      <= '0;
      w_loaded   <= 1'b0;
      pred_count <= '0;
    end else begin
      case (state)
        NOWT: begin
          if (w_load) begin
            w_reg    <= weights;
            w_loaded <= 1'b1;
            x_ready  <= 1'b1;
            state    <= READY;
          end
        end
        READY: begin
          if (w_load) begin
            w_reg    <= weights;
            w_loaded <= 1'b1;
          end
          if (x_hs) begin
            x_reg    <= x_data;
            feat_reg <= feat;
            acc      <= acc_nxt;
            idx      <= 4'd1;
            x_ready  <= 1'b0;
            if (feat != 4'd0) begin
              state <= MAC;
            end else begin
              state   <= OUT;
              y_valid <= 1'b1;
              y_cap   <= y_cap_nxt;
              y_err   <= y_err_nxt;
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          idx <= idx + 4'd1;
          if (idx == feat_reg) begin
            state   <= OUT;
            y_valid <= 1'b1;
            y_cap   <= y_cap_nxt;
            y_err   <= y_err_nxt;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid    <= 1'b0;
            pred_count <= pred_count + ADDR_WIDTH'(1);
            x_ready    <= 1'b1;
            state      <= READY;
          end
        end
        default: state <= NOWT;
      endcase
    end
  end

endmodule

// File: tb/tb_linreg_predict.sv
`timescale 1ns/1ps
// Self-checking bench for linreg_predict: directed corner rows plus random rows
// compared against an integer-arithmetic model of the prediction.
module tb_linreg_predict;

  localparam int DW = 256;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          w_load;
  logic [DW-1:0] weights;
  logic [3:0]    feat;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          y_valid;
  logic          y_ready;
  logic [15:0]   y_cap;
  logic [15:0]   y_err;
  logic          w_loaded;
  logic [11:0]   pred_count;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] cur_w;
  logic [11:0]   pred_exp;

  linreg_predict dut (
    .CLK(CLK), .RST_N(RST_N), .w_load(w_load), .weights(weights), .feat(feat),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .y_valid(y_valid),
    .y_ready(y_ready), .y_cap(y_cap), .y_err(y_err), .w_loaded(w_loaded),
    .pred_count(pred_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] fld(input logic [DW-1:0] v, input int j);
    fld = v[DW-1-16*j -: 16];
  endfunction

  function automatic logic [DW-1:0] setf(input logic [DW-1:0] v, input int j, input logic [15:0] val);
    setf = v;
    setf[DW-1-16*j -: 16] = val;
  endfunction

  function automatic logic [15:0] rnd16();
    if ($urandom_range(0, 3) == 0) rnd16 = 16'($urandom);
    else                           rnd16 = 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v = '0;
    for (int j = 0; j < 16; j++) v = setf(v, j, rnd16());
    return v;
  endfunction

  // Real-valued prediction scaled by 2^8, floored, clamped to 16-bit signed.
  function automatic void model(input logic [DW-1:0] w, input logic [DW-1:0] row, input int f,
                                output logic [15:0] cap, output logic [15:0] err);
    longint acc, c, e;
    acc = longint'(fld(w, 0)) * 256;
    for (int j = 1; j <= f; j++) acc += longint'(fld(w, j)) * longint'(fld(row, j));
    c = acc >>> 8;
    if (c > 32767) c = 32767;
    else if (c < -32768) c = -32768;
    e = longint'(fld(row, 0)) - c;
    if (e > 32767) e = 32767;
    else if (e < -32768) e = -32768;
    cap = c[15:0];
    err = e[15:0];
  endfunction

  task automatic load_w(input logic [DW-1:0] w);
    @(negedge CLK);
    w_load = 1'b1;
    weights = w;
    @(negedge CLK);
    w_load = 1'b0;
    cur_w = w;
    chk("wl_loaded", w_loaded, 1);
    chk("wl_xready", x_ready, 1);
  endtask

  task automatic run_row(input string tag, input logic [DW-1:0] row, input logic [3:0] f,
                         input int bp, input bit hs_wload, input logic [DW-1:0] hs_w,
                         input bit bp_wload, input logic [DW-1:0] bp_w,
                         output logic [15:0] ocap, output logic [15:0] oerr);
    int t = 0;
    int lat;
    logic [15:0] ecap, eerr;
    ocap = '0;
    oerr = '0;
    @(negedge CLK);
    while (!x_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!x_ready) begin
      chk({tag, "_xready_timeout"}, x_ready, 1);
      return;
    end
    x_data = row;
    feat = f;
    x_valid = 1'b1;
    if (hs_wload) begin
      w_load = 1'b1;
      weights = hs_w;
      cur_w = hs_w;
    end
    model(cur_w, row, int'(f), ecap, eerr);
    @(negedge CLK);
    x_valid = 1'b0;
    w_load = 1'b0;
    lat = 1;
    while (!y_valid && lat < 40) begin
      chk({tag, "_xready_mac"}, x_ready, 0);
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, lat, int'(f) + 1);
    chk({tag, "_cap"}, y_cap, ecap);
    chk({tag, "_err"}, y_err, eerr);
    chk({tag, "_xready_out"}, x_ready, 0);
    ocap = y_cap;
    oerr = y_err;
    for (int i = 0; i < bp; i++) begin
      if (bp_wload && i == 0) begin
        w_load = 1'b1;
        weights = bp_w;
      end
      @(negedge CLK);
      w_load = 1'b0;
      chk({tag, "_bp_valid"}, y_valid, 1);
      chk({tag, "_bp_cap"}, y_cap, ecap);
      chk({tag, "_bp_err"}, y_err, eerr);
      chk({tag, "_bp_xready"}, x_ready, 0);
    end
    y_ready = 1'b1;
    @(negedge CLK);
    y_ready = 1'b0;
    pred_exp++;
    chk({tag, "_pred_count"}, pred_count, pred_exp);
    chk({tag, "_valid_drop"}, y_valid, 0);
    chk({tag, "_xready_back"}, x_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] w, r;
    logic [15:0]   c, e;
    int            guard;

    RST_N = 1'b0;
    w_load = 1'b0;
    weights = '0;
    feat = '0;
    x_valid = 1'b0;
    x_data = '0;
    y_ready = 1'b0;
    cur_w = '0;
    pred_exp = '0;
    repeat (3) @(negedge CLK);
    chk("rst_xready", x_ready, 0);
    chk("rst_yvalid", y_valid, 0);
    chk("rst_ycap", y_cap, 0);
    chk("rst_yerr", y_err, 0);
    chk("rst_wloaded", w_loaded, 0);
    chk("rst_pcount", pred_count, 0);
    RST_N = 1'b1;

    // Rows offered before any weights are refused.
    x_valid = 1'b1;
    x_data = rand_vec();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("nowt_xready", x_ready, 0);
      chk("nowt_yvalid", y_valid, 0);
    end
    x_valid = 1'b0;

    // Basic: 1.0 + 2.0*1.5 = 4.0, y = 5.0.
    w = '0; w = setf(w, 0, 16'h0100); w = setf(w, 1, 16'h0200);
    load_w(w);
    r = '0; r = setf(r, 0, 16'h0500); r = setf(r, 1, 16'h0180);
    run_row("basic", r, 4'd1, 0, 0, '0, 0, '0, c, e);
    chk("basic_cap_const", c, 16'h0400);
    chk("basic_err_const", e, 16'h0100);

    // feat=0: prediction is W0 alone.
    w = '0; w = setf(w, 0, 16'hFF00); w = setf(w, 1, 16'h1234);
    load_w(w);
    r = rand_vec(); r = setf(r, 0, 16'h0000);
    run_row("feat0", r, 4'd0, 0, 0, '0, 0, '0, c, e);
    chk("feat0_cap_const", c, 16'hFF00);
    chk("feat0_err_const", e, 16'h0100);

    // Positive saturation of y_cap, negative saturation of y_err.
    w = '0; w = setf(w, 0, 16'h7FFF); w = setf(w, 1, 16'h7FFF);
    load_w(w);
    r = '0; r = setf(r, 0, 16'h8000); r = setf(r, 1, 16'h7FFF);
    run_row("sat", r, 4'd1, 0, 0, '0, 0, '0, c, e);
    chk("sat_cap_const", c, 16'h7FFF);
    chk("sat_err_const", e, 16'h8000);

    // Backpressure 10 cycles with an ignored w_load, then same row on old weights.
    w = rand_vec();
    load_w(w);
    r = rand_vec();
    run_row("bp", r, 4'd5, 10, 0, '0, 1, rand_vec(), c, e);
    run_row("bp_after", r, 4'd5, 0, 0, '0, 0, '0, c, e);

    // All 15 features at 1.0*1.0.
    w = '0;
    for (int j = 1; j < 16; j++) w = setf(w, j, 16'h0100);
    load_w(w);
    r = '0;
    for (int j = 1; j < 16; j++) r = setf(r, j, 16'h0100);
    run_row("full15", r, 4'd15, 0, 0, '0, 0, '0, c, e);
    chk("full15_cap_const", c, 16'h0F00);
    // Fields beyond feat must not contribute.
    for (int j = 4; j < 16; j++) r = setf(r, j, 16'h7FFF);
    run_row("feat3", r, 4'd3, 0, 0, '0, 0, '0, c, e);
    chk("feat3_cap_const", c, 16'h0300);

    // w_load coinciding with the row handshake: new weights used for the row.
    run_row("hs_wload", rand_vec(), 4'd4, 1, 1, rand_vec(), 0, '0, c, e);

    // Random rows.
    for (int n = 0; n < 40; n++) begin
      int mode, bp;
      mode = int'($urandom_range(0, 5));
      bp = int'($urandom_range(0, 3));
      if (mode == 0) load_w(rand_vec());
      run_row("rnd", rand_vec(), 4'($urandom_range(0, 15)), bp, mode == 1, rand_vec(),
              (bp > 0) && (mode == 2), rand_vec(), c, e);
    end

    // Drive pred_count through its wrap with quick feat=0 rows.
    guard = 0;
    r = rand_vec();
    while (pred_exp != 12'd0 && guard < 5000) begin
      x_data = r;
      feat = 4'd0;
      x_valid = 1'b1;
      @(negedge CLK);
      x_valid = 1'b0;
      y_ready = 1'b1;
      @(negedge CLK);
      y_ready = 1'b0;
      pred_exp++;
      if (pred_exp == 12'hFFF) chk("pcount_max", pred_count, 12'hFFF);
      guard++;
    end
    chk("pcount_wrap", pred_count, 12'h000);
    chk("pcount_wrap_ready", x_ready, 1);

    // Reset in the middle of a 15-feature accumulation.
    w = rand_vec();
    load_w(w);
    @(negedge CLK);
    x_data = rand_vec();
    feat = 4'd15;
    x_valid = 1'b1;
    @(negedge CLK);
    x_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mrst_xready", x_ready, 0);
    chk("mrst_yvalid", y_valid, 0);
    chk("mrst_ycap", y_cap, 0);
    chk("mrst_yerr", y_err, 0);
    chk("mrst_wloaded", w_loaded, 0);
    chk("mrst_pcount", pred_count, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    pred_exp = '0;
    x_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("post_rst_xready", x_ready, 0);
      chk("post_rst_yvalid", y_valid, 0);
    end
    x_valid = 1'b0;
    load_w(rand_vec());
    run_row("post_rst", rand_vec(), 4'd7, 2, 0, '0, 0, '0, c, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/linreg_predict.md
LINREG_PREDICT -- requirements
Module: linreg_predict

Interface
REQ-001 Parameter: LENGTH, 16, width of one fixed-point field.
REQ-002 Parameter: MAX_FEATURES, 15, maximum feature count.
REQ-003 Parameter: FRAC, 8, fractional bits; fields are signed Q(LENGTH-FRAC).FRAC.
REQ-004 Parameter: DATA_WIDTH, LENGTH*(MAX_FEATURES+1), packed row/weight-vector width.
REQ-005 Parameter: ADDR_WIDTH, 12, prediction counter width.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 w_load  in  1  one-cycle strobe: capture weights.
REQ-009 weights  in  DATA_WIDTH  packed W0..W15, W0 in bits [DATA_WIDTH-1 -: LENGTH], Wj at [DATA_WIDTH-1-LENGTH*j -: LENGTH].
REQ-010 feat  in  4  active feature count (0..15), sampled on x handshake.
REQ-011 x_valid  in  1  input row valid.
REQ-012 x_ready  out  1  block accepts a row.
REQ-013 x_data  in  DATA_WIDTH  packed row; field 0 = y (target), field j = feature xj, same layout as weights.
REQ-014 y_valid  out  1  prediction valid.
REQ-015 y_ready  in  1  consumer accepts prediction.
REQ-016 y_cap  out  LENGTH  saturated prediction W0 + sum(Wj*xj).
REQ-017 y_err  out  LENGTH  saturated y - y_cap.
REQ-018 w_loaded  out  1  a weight set has been captured since reset.
REQ-019 pred_count  out  ADDR_WIDTH  number of predictions delivered.

Function
REQ-020 States SHALL be NOWT (no weights), READY, MAC, OUT.
REQ-021 NOWT: x_ready=0; w_load -> capture all 16 weights, w_loaded<=1, go READY.
REQ-022 READY: x_ready=1; w_load honoured (weights replaced); x_valid&x_ready -> latch x_data fields, feat, acc<=sign-extended W0<<FRAC, idx<=1; go MAC if feat!=0, else OUT.
REQ-023 Simultaneous w_load and x handshake in READY: new weights SHALL be captured and used for that row.
REQ-024 MAC: one product per cycle, p = Wi*xi full 2*LENGTH-bit signed, acc += p; acc SHALL be 2*LENGTH+4 bits so 15 products never overflow; idx++; after idx==feat go OUT.
REQ-025 w_load in MAC or OUT SHALL be ignored (weights unchanged).
REQ-026 OUT: y_valid=1; y_cap = saturate(acc>>>FRAC) to [-2^(LENGTH-1), 2^(LENGTH-1)-1]; y_err = saturate(y - y_cap) computed at LENGTH+1 bits; outputs stable while y_valid&!y_ready.
REQ-027 OUT with y_ready: pred_count++ (wraps to 0 after 2^ADDR_WIDTH-1), go READY.
REQ-028 Latency: y_valid asserted feat+1 cycles after x handshake edge (1 cycle for feat=0).
REQ-029 Throughput: next x accepted no earlier than cycle after y handshake; x_ready=0 in MAC and OUT.
REQ-030 Features with index > feat SHALL not affect y_cap.
REQ-031 Right shift SHALL be arithmetic (truncate toward -inf).

Reset
REQ-032 RST_N low asynchronously: state NOWT, x_ready=0, y_valid=0, y_cap=0, y_err=0, w_loaded=0, pred_count=0, weights and acc cleared.
REQ-033 Reset asserted mid-MAC or mid-OUT SHALL discard the row; no y_valid after release until new weights and row.
REQ-034 Release is synchronised to CLK by the integrator; the block needs no reset weight reload other than w_load.

Verification
REQ-035 Basic: w_load W0=0x0100,W1=0x0200; row y=0x0500,x1=0x0180, feat=1 -> y_valid 2 cycles after handshake, y_cap=0x0400, y_err=0x0100, pred_count=1.
REQ-036 feat=0: W0=0xFF00 (-1.0), any row y=0 -> y_cap=0xFF00, y_err=0x0100, latency 1 cycle.
REQ-037 Saturation: W1=0x7FFF,x1=0x7FFF,W0=0x7FFF, feat=1 -> y_cap=0x7FFF; y=0x8000 -> y_err=0x8000.
REQ-038 Backpressure: hold y_ready=0 10 cycles -> y_valid, y_cap stable, x_ready=0, w_load in that window ignored (next row uses old weights).
REQ-039 Full feat=15, all Wj=0x0100, xj=0x0100, W0=0 -> y_cap=0x0F00 after 16 cycles; unused fields set to 0x7FFF with feat=3 -> y_cap=0x0300.
REQ-040 Reset mid-MAC (feat=15, RST_N low at cycle 5) -> all outputs 0, NOWT; row before w_load never accepted (x_ready=0).
